// File: rtl/mux_arb_pkg.sv
// Shared constants, state type and sizing helper
// for the 16-input mux arbiter.
package mux_arb_pkg;

    localparam int NR_REQ = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } arbStateT;

    function automatic int holdW(input int maxHold);
        int w;
        w = $clog2(maxHold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Rotate-priority encoder: first set request at or
// above ptr, wrapping 15 -> 0.
module rr_pick16
    import mux_arb_pkg::*;
(
    input  logic [NR_REQ-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [SEL_W-1:0] cand;

    // Walk offsets high to low so the smallest offset wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = NR_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter_16.sv
// Round-robin owner arbiter for the 16-input mux with
// bounded hold and a one-cycle break-before-make gap.
module mux_arbiter_16
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NR_REQ-1:0] req,
    input  logic              release_i,
    output logic [SEL_W-1:0]  sel,
    output logic              mux_en,
    output logic [NR_REQ-1:0] grant,
    output logic              busy
);

    localparam int CW = holdW(MAX_HOLD);
    localparam bit HOLD_ON = (MAX_HOLD != 0);
    localparam logic [CW-1:0] HOLD_LAST =
        HOLD_ON ? CW'(MAX_HOLD - 1) : '0;

    arbStateT          state, stateNext;
    logic [SEL_W-1:0]  ptr, ptrNext;
    logic [CW-1:0]     cnt, cntNext;
    logic [SEL_W-1:0]  selNext;
    logic [NR_REQ-1:0] grantNext;
    logic              muxEnNext;
    logic              busyNext;

    logic              found;
    logic [SEL_W-1:0]  winner;
    logic              contended;
    logic              exitOwn;

    rr_pick16 uPick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (winner)
    );

    // grant is one-hot of sel while owning, so this masks the owner.
    assign contended = |(req & ~grant);
    assign exitOwn   = release_i || !req[sel] ||
                       (HOLD_ON && cnt == HOLD_LAST && contended);

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        cntNext   = cnt;
        selNext   = sel;
        grantNext = grant;
        muxEnNext = mux_en;
        busyNext  = busy;
        unique case (state)
            IDLE, GAP: begin
                if (found) begin
                    stateNext = OWN;
                    selNext   = winner;
                    grantNext = NR_REQ'(1) << winner;
                    muxEnNext = 1'b1;
                    busyNext  = 1'b1;
                    cntNext   = '0;
                end else begin
                    stateNext = IDLE;
                    grantNext = '0;
                    muxEnNext = 1'b0;
                    busyNext  = 1'b0;
                end
            end
            OWN: begin
                if (exitOwn) begin
                    stateNext = GAP;
                    ptrNext   = sel + SEL_W'(1);
                    grantNext = '0;
                    muxEnNext = 1'b0;
                    busyNext  = 1'b0;
                end else if (cnt != HOLD_LAST) begin
                    cntNext = cnt + CW'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                grantNext = '0;
                muxEnNext = 1'b0;
                busyNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            sel    <= '0;
            grant  <= '0;
            mux_en <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= stateNext;
            ptr    <= ptrNext;
            cnt    <= cntNext;
            sel    <= selNext;
            grant  <= grantNext;
            mux_en <= muxEnNext;
            busy   <= busyNext;
        end
    end

endmodule

// File: tb/tb_mux_arbiter_16.sv
// Randomized and directed bench for mux_arbiter_16
// against an ownership-level reference model.
module tb_mux_arbiter_16;

    localparam int MAXH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        release_i = 1'b0;
    logic [3:0]  sel;
    logic        mux_en;
    logic [15:0] grant;
    logic        busy;

    int nCmp = 0;
    int nBad = 0;

    int mOwner = -1;
    int mPtr   = 0;
    int mLast  = 0;
    int mHeld  = 0;

    always #5 clk = ~clk;

    mux_arbiter_16 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .release_i (release_i),
        .sel       (sel),
        .mux_en    (mux_en),
        .grant     (grant),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++)
            if (r[(p + k) % 16]) return (p + k) % 16;
        return -1;
    endfunction

    task automatic modelReset();
        mOwner = -1;
        mPtr   = 0;
        mLast  = 0;
        mHeld  = 0;
    endtask

    // One clock of the ownership model.
    task automatic modelEdge(input logic [15:0] r, input logic rel);
        int w;
        logic [15:0] others;
        if (mOwner >= 0) begin
            mHeld++;
            others = r & ~(16'(1) << mOwner);
            if (rel || !r[mOwner] ||
                (MAXH != 0 && mHeld >= MAXH && others != 0)) begin
                mPtr   = (mOwner + 1) % 16;
                mOwner = -1;
            end
        end else begin
            w = pick(r, mPtr);
            if (w >= 0) begin
                mOwner = w;
                mLast  = w;
                mHeld  = 0;
            end
        end
    endtask

    task automatic checkOut();
        logic [31:0] g;
        g = (mOwner >= 0) ? (32'(1) << mOwner) : 32'(0);
        chk("sel", 32'(sel), 32'(mLast));
        chk("grant", 32'(grant), g);
        chk("mux_en", 32'(mux_en), 32'(mOwner >= 0));
        chk("busy", 32'(busy), 32'(mOwner >= 0));
    endtask

    task automatic step(input logic [15:0] r, input logic rel);
        @(negedge clk);
        rst_n     = 1'b1;
        req       = r;
        release_i = rel;
        @(posedge clk);
        modelEdge(r, rel);
        #1;
        checkOut();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = '0;
        release_i = 1'b0;
        modelReset();
        #1;
        chk("rst_sel", 32'(sel), 32'(0));
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_mux_en", 32'(mux_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        logic [15:0] r;
        logic rel;

        // reset, idle, first grant
        doReset();
        step(16'h0000, 1'b0);
        step(16'h0020, 1'b0);
        chk("first_sel", 32'(sel), 32'd5);
        chk("first_grant", 32'(grant), 32'h0020);
        chk("first_en", 32'(mux_en), 32'd1);
        chk("first_busy", 32'(busy), 32'd1);

        // round robin with release
        doReset();
        for (int i = 0; i < 4; i++) begin
            step(16'h8001, 1'b0);
            chk("rr_sel", 32'(sel), (i % 2) ? 32'd15 : 32'd0);
            step(16'h8001, 1'b0);
            step(16'h8001, 1'b1);
            chk("rr_gap", 32'(mux_en), 32'd0);
        end

        // preemption by hold limit
        doReset();
        for (int i = 0; i < 20; i++) begin
            step(16'h0003, 1'b0);
            if (i == 4) chk("pre_gap", 32'(mux_en), 32'd0);
            if (i == 5) chk("pre_sel", 32'(sel), 32'd1);
            if (i == 11) chk("pre_back", 32'(grant), 32'h0001);
        end

        // uncontended hold never preempts
        doReset();
        step(16'h0004, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(16'h0004, 1'b0);
            chk("unc_sel", 32'(sel), 32'd2);
            chk("unc_en", 32'(mux_en), 32'd1);
        end

        // request drop, wrap-around scan
        doReset();
        step(16'h0080, 1'b0);
        step(16'h0080, 1'b0);
        step(16'h0041, 1'b0);
        chk("drop_gap", 32'(mux_en), 32'd0);
        step(16'h0041, 1'b0);
        chk("drop_sel", 32'(sel), 32'd0);

        // asynchronous reset mid-grant
        doReset();
        step(16'h0200, 1'b0);
        step(16'h0200, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_en", 32'(mux_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sel", 32'(sel), 32'd0);
        step(16'h0200, 1'b0);
        chk("arst_regrant", 32'(sel), 32'd9);

        // random traffic
        doReset();
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            rel = ($urandom_range(0, 7) == 0);
            step(r, rel);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule
